// File: rtl/py_pkg.sv
// py_pkg: shared state encoding, FIFO geometry and header layout for the payload receive assembler.
package py_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_CRC, ST_DONE} py_state_t;
   localparam int FIFO_DEPTH = 8;
   localparam int FIFO_AW = 3;
   localparam int HDR1_BITS = 8;
   localparam int HDR2_BITS = 16;
   typedef struct packed {
      logic [1:0] llid;
      logic       flow;
      logic [9:0] pylen;
   } py_hdr_t;
   // bits[15:13] of a 2-byte header carry nothing we use
   function automatic py_hdr_t py_hdr_decode(input logic [15:0] h, input logic two);
      py_hdr_t d;
      d.llid  = h[1:0];
      d.flow  = h[2];
      d.pylen = two ? h[12:3] : {5'd0, h[7:3]};
      return d;
   endfunction
endpackage

// File: rtl/py_bytefifo.sv
// py_bytefifo: 8-entry first-word-fall-through byte FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module py_bytefifo
   import py_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rstz,
   input  logic       i_flush,
   input  logic       i_push,
   input  logic [7:0] i_din,
   input  logic       i_pop,
   output logic [7:0] o_dout,
   output logic       o_avail,
   output logic       o_drop
);
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [FIFO_AW-1:0] r_wp, r_rp;
   logic [FIFO_AW:0]   r_cnt;
   logic               w_full, w_pop, w_push;
   assign w_full  = r_cnt == (FIFO_AW+1)'(FIFO_DEPTH);
   assign o_avail = r_cnt != '0;
   assign w_pop   = i_pop & o_avail;
   assign w_push  = i_push & (~w_full | w_pop);
   assign o_drop  = i_push & w_full & ~w_pop & ~i_flush;
   assign o_dout  = o_avail ? r_mem[r_rp] : '0;
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop) r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + {3'd0, w_push} - {3'd0, w_pop};
      end
   end
   always_ff @(posedge clk_6M) begin
      if (w_push && !i_flush) r_mem[r_wp] <= i_din;
   end
endmodule

// File: rtl/py_rxasm.sv
// py_rxasm: assembles the decoded receive payload bit stream into header fields and data bytes,
// buffering bytes in a small FIFO and reporting completion, CRC, truncation and overflow.
module py_rxasm
   import py_pkg::*;
(
   input  logic       clk_6M,
   input  logic       rstz,
   input  logic       dec_py_st_p,
   input  logic       dec_py_period,
   input  logic       daten,
   input  logic       py_datvalid_p,
   input  logic       pydecdatout,
   input  logic       dec_py_endp,
   input  logic       dec_crcgood,
   input  logic       hdr2byte,
   input  logic       rd_p,
   output logic [7:0] rxbyte,
   output logic       rxbyte_avail,
   output logic [1:0] llid,
   output logic       flow,
   output logic [9:0] pylen,
   output logic       hdr_valid_p,
   output logic       rx_done_p,
   output logic       rx_crcok,
   output logic       rx_trunc,
   output logic       rx_ovf
);
   py_state_t   r_state, w_next;
   logic [15:0] r_hdr, w_hdr;
   logic [3:0]  r_bitcnt;
   logic [6:0]  r_byte;
   logic [9:0]  r_bytecnt;
   logic        r_hdr2, r_push;
   logic [7:0]  r_pbyte;
   logic [1:0]  r_llid;
   logic        r_flow;
   logic [9:0]  r_pylen;
   logic        r_hdr_valid_p, r_done_p, r_crcok, r_trunc, r_ovf;
   py_hdr_t     w_dec;
   logic        w_strb, w_active, w_last_hbit, w_last_dbit, w_last_byte, w_drop;
   assign w_strb      = dec_py_period & daten & py_datvalid_p;
   assign w_active    = r_state == ST_HDR || r_state == ST_DATA || r_state == ST_CRC;
   assign w_last_hbit = r_state == ST_HDR && w_strb &&
                        r_bitcnt == (r_hdr2 ? 4'(HDR2_BITS-1) : 4'(HDR1_BITS-1));
   assign w_last_dbit = r_state == ST_DATA && w_strb && r_bitcnt[2:0] == 3'd7;
   assign w_last_byte = w_last_dbit && (r_bytecnt + 10'd1 == r_pylen);
   always_comb begin
      w_hdr = r_hdr;
      w_hdr[r_bitcnt] = pydecdatout;
      w_dec = py_hdr_decode(w_hdr, r_hdr2);
   end
   always_comb begin
      w_next = r_state;
      if (dec_py_st_p) w_next = ST_HDR;
      else if (dec_py_endp && w_active) w_next = ST_DONE;
      else if (w_last_hbit) w_next = w_dec.pylen != '0 ? ST_DATA : ST_CRC;
      else if (w_last_byte) w_next = ST_CRC;
      else if (r_state == ST_DONE) w_next = ST_IDLE;
   end
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) r_state <= ST_IDLE;
      else r_state <= w_next;
   end
   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         r_hdr         <= '0;
         r_bitcnt      <= '0;
         r_byte        <= '0;
         r_bytecnt     <= '0;
         r_hdr2        <= 1'b0;
         r_push        <= 1'b0;
         r_pbyte       <= '0;
         r_llid        <= '0;
         r_flow        <= 1'b0;
         r_pylen       <= '0;
         r_hdr_valid_p <= 1'b0;
         r_done_p      <= 1'b0;
         r_crcok       <= 1'b0;
         r_trunc       <= 1'b0;
         r_ovf         <= 1'b0;
      end else begin
         r_hdr_valid_p <= 1'b0;
         r_done_p      <= 1'b0;
         r_push        <= 1'b0;
         if (dec_py_st_p) begin
            r_hdr     <= '0;
            r_bitcnt  <= '0;
            r_bytecnt <= '0;
            r_hdr2    <= hdr2byte;
            r_trunc   <= 1'b0;
            r_ovf     <= 1'b0;
         end else begin
            if (w_drop) r_ovf <= 1'b1;
            if (r_state == ST_HDR && w_strb) begin
               r_hdr    <= w_hdr;
               r_bitcnt <= w_last_hbit ? 4'd0 : r_bitcnt + 4'd1;
            end
            if (w_last_hbit) begin
               r_llid        <= w_dec.llid;
               r_flow        <= w_dec.flow;
               r_pylen       <= w_dec.pylen;
               r_hdr_valid_p <= 1'b1;
            end
            // byte shifts in LSB first; the 8th bit goes straight into the push register
            if (r_state == ST_DATA && w_strb) begin
               r_byte   <= {pydecdatout, r_byte[6:1]};
               r_bitcnt <= w_last_dbit ? 4'd0 : r_bitcnt + 4'd1;
            end
            if (w_last_dbit) begin
               r_pbyte   <= {pydecdatout, r_byte};
               r_push    <= 1'b1;
               r_bytecnt <= r_bytecnt + 10'd1;
            end
            if (dec_py_endp && (r_state == ST_HDR || r_state == ST_DATA)) begin
               r_trunc  <= 1'b1;
               r_bitcnt <= '0;
            end
            if (r_state == ST_DONE) begin
               r_crcok  <= dec_crcgood;
               r_done_p <= 1'b1;
            end
         end
      end
   end
   py_bytefifo u_fifo (
      .clk_6M  (clk_6M),
      .rstz    (rstz),
      .i_flush (dec_py_st_p),
      .i_push  (r_push),
      .i_din   (r_pbyte),
      .i_pop   (rd_p),
      .o_dout  (rxbyte),
      .o_avail (rxbyte_avail),
      .o_drop  (w_drop)
   );
   assign llid        = r_llid;
   assign flow        = r_flow;
   assign pylen       = r_pylen;
   assign hdr_valid_p = r_hdr_valid_p;
   assign rx_done_p   = r_done_p;
   assign rx_crcok    = r_crcok;
   assign rx_trunc    = r_trunc;
   assign rx_ovf      = r_ovf;
endmodule

// File: tb/tb_py_rxasm.sv
// tb_py_rxasm: directed and randomized packets checked against a byte-queue model of the payload.
`timescale 1ns/1ps
module tb_py_rxasm;
   logic       clk_6M = 1'b0, rstz = 1'b0;
   logic       dec_py_st_p = 1'b0, dec_py_period = 1'b0, daten = 1'b0, py_datvalid_p = 1'b0;
   logic       pydecdatout = 1'b0, dec_py_endp = 1'b0, dec_crcgood = 1'b0, hdr2byte = 1'b0, rd_p = 1'b0;
   logic [7:0] rxbyte;
   logic       rxbyte_avail, flow, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf;
   logic [1:0] llid;
   logic [9:0] pylen;
   int         checks = 0, errors = 0, hv_cnt = 0, done_cnt = 0;
   logic [7:0] pkt [16];
   logic [7:0] expq [$];

   always #83 clk_6M = ~clk_6M;

   py_rxasm dut (
      .clk_6M(clk_6M), .rstz(rstz), .dec_py_st_p(dec_py_st_p), .dec_py_period(dec_py_period),
      .daten(daten), .py_datvalid_p(py_datvalid_p), .pydecdatout(pydecdatout),
      .dec_py_endp(dec_py_endp), .dec_crcgood(dec_crcgood), .hdr2byte(hdr2byte), .rd_p(rd_p),
      .rxbyte(rxbyte), .rxbyte_avail(rxbyte_avail), .llid(llid), .flow(flow), .pylen(pylen),
      .hdr_valid_p(hdr_valid_p), .rx_done_p(rx_done_p), .rx_crcok(rx_crcok),
      .rx_trunc(rx_trunc), .rx_ovf(rx_ovf)
   );

   always @(negedge clk_6M) begin
      if (hdr_valid_p) hv_cnt++;
      if (rx_done_p) done_cnt++;
   end

   initial begin
      #20_000_000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_6M);
      #1;
   endtask

   task automatic send_bit(input logic b);
      repeat ($urandom_range(0, 2)) begin
         {dec_py_period, daten, py_datvalid_p} = 3'($urandom_range(0, 6));
         pydecdatout = 1'($urandom);
         tick();
      end
      {dec_py_period, daten, py_datvalid_p} = 3'b111;
      pydecdatout = b;
      tick();
      {dec_py_period, daten, py_datvalid_p} = 3'b000;
   endtask

   task automatic send_bits(input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) send_bit(v[i]);
   endtask

   task automatic pulse_st(input logic h2);
      dec_py_st_p = 1'b1;
      hdr2byte = h2;
      tick();
      dec_py_st_p = 1'b0;
      hdr2byte = 1'($urandom);
   endtask

   task automatic send_end(input logic crc);
      dec_py_endp = 1'b1;
      tick();
      dec_py_endp = 1'b0;
      dec_crcgood = crc;
      tick();
      dec_crcgood = 1'b0;
      tick();
      tick();
   endtask

   task automatic send_hdr(input logic h2, input logic [1:0] ll, input logic fl, input logic [9:0] pl);
      pulse_st(h2);
      if (h2) send_bits({3'($urandom), pl, fl, ll}, 16);
      else send_bits({8'h00, pl[4:0], fl, ll}, 8);
   endtask

   task automatic run_pkt(input logic h2, input logic [1:0] ll, input logic fl, input logic [9:0] pl,
                          input int nb, input logic crc);
      send_hdr(h2, ll, fl, pl);
      for (int i = 0; i < nb; i++) send_bit(pkt[i / 8][i % 8]);
      if (nb == int'(pl) * 8) send_bits(16'($urandom), 16);
      send_end(crc);
   endtask

   task automatic pop_all(input string nm);
      logic [7:0] e;
      while (expq.size() > 0) begin
         e = expq.pop_front();
         checks++;
         if ({rxbyte_avail, rxbyte} !== {1'b1, e}) begin
            errors++;
            $display("FAIL %s pop: avail/byte got %b/%h exp 1/%h", nm, rxbyte_avail, rxbyte, e);
         end
         rd_p = 1'b1;
         tick();
         rd_p = 1'b0;
      end
      checks++;
      if (rxbyte_avail !== 1'b0) begin
         errors++;
         $display("FAIL %s empty: rxbyte_avail got %b exp 0", nm, rxbyte_avail);
      end
   endtask

   task automatic test_reset();
      #20;
      checks++;
      if ({rxbyte, rxbyte_avail, llid, flow, pylen, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf} !== '0) begin
         errors++;
         $display("FAIL reset outputs: got %h exp 0",
                  {rxbyte, rxbyte_avail, llid, flow, pylen, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf});
      end
      tick();
      tick();
      #40 rstz = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int hv0, d0;
      hv0 = hv_cnt;
      d0 = done_cnt;
      pkt[0] = 8'h55; pkt[1] = 8'hAA; pkt[2] = 8'h0F;
      run_pkt(1'b0, 2'd2, 1'b0, 10'd3, 24, 1'b1);
      checks++;
      if (hv_cnt - hv0 !== 1) begin errors++; $display("FAIL basic hdr_valid count got %0d exp 1", hv_cnt - hv0); end
      checks++;
      if ({llid, flow, pylen} !== {2'd2, 1'b0, 10'd3}) begin
         errors++; $display("FAIL basic header got llid=%0d flow=%0d pylen=%0d exp 2 0 3", llid, flow, pylen);
      end
      checks++;
      if ({done_cnt - d0, rx_crcok, rx_trunc, rx_ovf} !== {32'd1, 3'b100}) begin
         errors++; $display("FAIL basic status got done=%0d crcok=%b trunc=%b ovf=%b exp 1 1 0 0",
                            done_cnt - d0, rx_crcok, rx_trunc, rx_ovf);
      end
      expq = '{8'h55, 8'hAA, 8'h0F};
      pop_all("basic");
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 10; i++) pkt[i] = 8'($urandom);
      run_pkt(1'b1, 2'd1, 1'b1, 10'd10, 80, 1'b1);
      checks++;
      if ({pylen, rx_ovf, rx_trunc} !== {10'd10, 2'b10}) begin
         errors++; $display("FAIL ovf status got pylen=%0d ovf=%b trunc=%b exp 10 1 0", pylen, rx_ovf, rx_trunc);
      end
      for (int i = 0; i < 8; i++) expq.push_back(pkt[i]);
      pop_all("ovf");
   endtask

   task automatic test_zero_len();
      int d0;
      d0 = done_cnt;
      run_pkt(1'b0, 2'd3, 1'b1, 10'd0, 0, 1'b1);
      checks++;
      if ({rxbyte_avail, rx_trunc, done_cnt - d0, pylen} !== {2'b00, 32'd1, 10'd0}) begin
         errors++; $display("FAIL zerolen got avail=%b trunc=%b done=%0d pylen=%0d exp 0 0 1 0",
                            rxbyte_avail, rx_trunc, done_cnt - d0, pylen);
      end
   endtask

   task automatic test_trunc();
      for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
      run_pkt(1'b0, 2'd0, 1'b0, 10'd4, 20, 1'b0);
      checks++;
      if ({rx_trunc, rx_crcok} !== 2'b10) begin
         errors++; $display("FAIL trunc status got trunc=%b crcok=%b exp 1 0", rx_trunc, rx_crcok);
      end
      expq = '{pkt[0], pkt[1]};
      pop_all("trunc");
   endtask

   task automatic test_restart();
      for (int i = 0; i < 3; i++) pkt[i] = 8'($urandom);
      send_hdr(1'b0, 2'd0, 1'b0, 10'd5);
      for (int i = 0; i < 24; i++) send_bit(pkt[i / 8][i % 8]);
      tick();
      checks++;
      if ({rxbyte_avail, rxbyte} !== {1'b1, pkt[0]}) begin
         errors++; $display("FAIL restart pre got %b/%h exp 1/%h", rxbyte_avail, rxbyte, pkt[0]);
      end
      pulse_st(1'b1);
      checks++;
      if (rxbyte_avail !== 1'b0) begin errors++; $display("FAIL restart flush: avail got %b exp 0", rxbyte_avail); end
      send_bits({3'b101, 10'd1, 1'b1, 2'd1}, 16);
      send_bits(16'h00C3, 8);
      send_end(1'b1);
      checks++;
      if ({llid, flow, pylen, rx_trunc, rx_crcok} !== {2'd1, 1'b1, 10'd1, 2'b01}) begin
         errors++; $display("FAIL restart hdr got llid=%0d flow=%b pylen=%0d trunc=%b crcok=%b exp 1 1 1 0 1",
                            llid, flow, pylen, rx_trunc, rx_crcok);
      end
      expq = '{8'hC3};
      pop_all("restart");
   endtask

   task automatic test_full_pushpop();
      for (int i = 0; i < 12; i++) pkt[i] = 8'($urandom);
      send_hdr(1'b0, 2'd2, 1'b1, 10'd12);
      for (int i = 0; i < 64; i++) send_bit(pkt[i / 8][i % 8]);
      tick();
      for (int i = 64; i < 72; i++) send_bit(pkt[i / 8][i % 8]);
      checks++;
      if ({rxbyte_avail, rxbyte} !== {1'b1, pkt[0]}) begin
         errors++; $display("FAIL pushpop head got %b/%h exp 1/%h", rxbyte_avail, rxbyte, pkt[0]);
      end
      rd_p = 1'b1;
      tick();
      rd_p = 1'b0;
      send_end(1'b1);
      checks++;
      if ({rx_ovf, rx_trunc} !== 2'b01) begin
         errors++; $display("FAIL pushpop status got ovf=%b trunc=%b exp 0 1", rx_ovf, rx_trunc);
      end
      for (int i = 1; i < 9; i++) expq.push_back(pkt[i]);
      pop_all("pushpop");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 4; i++) pkt[i] = 8'($urandom);
      send_hdr(1'b0, 2'd3, 1'b1, 10'd4);
      for (int i = 0; i < 16; i++) send_bit(pkt[i / 8][i % 8]);
      tick();
      #20 rstz = 1'b0;
      #1;
      checks++;
      if ({rxbyte, rxbyte_avail, llid, flow, pylen, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf} !== '0) begin
         errors++;
         $display("FAIL reset mid outputs: got %h exp 0",
                  {rxbyte, rxbyte_avail, llid, flow, pylen, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf});
      end
      tick();
      #40 rstz = 1'b1;
      tick();
      pkt[0] = 8'h3C;
      run_pkt(1'b0, 2'd1, 1'b0, 10'd1, 8, 1'b1);
      checks++;
      if ({llid, pylen, rx_crcok, rx_trunc} !== {2'd1, 10'd1, 2'b10}) begin
         errors++; $display("FAIL reset recover got llid=%0d pylen=%0d crcok=%b trunc=%b exp 1 1 1 0",
                            llid, pylen, rx_crcok, rx_trunc);
      end
      expq = '{8'h3C};
      pop_all("recover");
   endtask

   task automatic test_random();
      logic       h2, fl, tr, crc;
      logic [1:0] ll;
      logic [9:0] pl;
      int         nb, comp, hv0, d0;
      for (int it = 0; it < 24; it++) begin
         h2 = 1'($urandom);
         ll = 2'($urandom);
         fl = 1'($urandom);
         crc = 1'($urandom);
         pl = 10'($urandom_range(0, 12));
         tr = pl != 0 && $urandom_range(0, 3) == 0;
         nb = tr ? $urandom_range(0, int'(pl) * 8 - 1) : int'(pl) * 8;
         for (int i = 0; i < 16; i++) pkt[i] = 8'($urandom);
         hv0 = hv_cnt;
         d0 = done_cnt;
         run_pkt(h2, ll, fl, pl, nb, crc);
         comp = nb / 8;
         checks++;
         if ({hv_cnt - hv0, llid, flow, pylen} !== {32'd1, ll, fl, pl}) begin
            errors++; $display("FAIL rand%0d header got hv=%0d llid=%0d flow=%b pylen=%0d exp 1 %0d %b %0d",
                               it, hv_cnt - hv0, llid, flow, pylen, ll, fl, pl);
         end
         checks++;
         if ({done_cnt - d0, rx_crcok, rx_trunc, rx_ovf} !== {32'd1, crc, tr, comp > 8}) begin
            errors++; $display("FAIL rand%0d status got done=%0d crcok=%b trunc=%b ovf=%b exp 1 %b %b %b",
                               it, done_cnt - d0, rx_crcok, rx_trunc, rx_ovf, crc, tr, comp > 8);
         end
         for (int i = 0; i < comp && i < 8; i++) expq.push_back(pkt[i]);
         pop_all("rand");
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_zero_len();
      test_trunc();
      test_restart();
      test_full_pushpop();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/py_rxasm.md
PY_RXASM -- requirements
Module: py_rxasm

Interface
REQ-001 SHALL have clk_6M, input, 1, 6 MHz system clock.
REQ-002 SHALL have rstz, input, 1, reset: asynchronous, active-low.
REQ-003 SHALL have dec_py_st_p, input, 1, one-cycle pulse marking receive payload start.
REQ-004 SHALL have dec_py_period, daten, py_datvalid_p, inputs, 1 each; a bit is accepted only when all three are high in the same cycle ("bit strobe").
REQ-005 SHALL have pydecdatout, input, 1, dewhitened, FEC-corrected payload bit, LSB first.
REQ-006 SHALL have dec_py_endp, input, 1, one-cycle pulse marking payload end (after CRC bits).
REQ-007 SHALL have dec_crcgood, input, 1, CRC verdict, valid the cycle after dec_py_endp.
REQ-008 SHALL have hdr2byte, input, 1; 1 = 2-byte payload header, 0 = 1-byte header; sampled at dec_py_st_p.
REQ-009 SHALL have rd_p, input, 1, pop one byte from the output FIFO.
REQ-010 SHALL have rxbyte, output, 8, FIFO head byte; rxbyte_avail, output, 1, FIFO not empty.
REQ-011 SHALL have llid (2), flow (1), pylen (10), outputs, latched header fields; hdr_valid_p, output, 1, header-complete pulse.
REQ-012 SHALL have rx_done_p, rx_crcok, rx_trunc, rx_ovf, outputs, 1 each.

Function
REQ-013 SHALL implement states IDLE, HDR, DATA, CRC, DONE.
REQ-014 SHALL, on dec_py_st_p in any state, enter HDR, clear bit/byte counters, flush FIFO, clear rx_trunc and rx_ovf.
REQ-015 SHALL in HDR shift 8 (hdr2byte=0) or 16 (hdr2byte=1) strobed bits LSB first.
REQ-016 SHALL decode header as bits[1:0]=llid, bit[2]=flow, pylen=bits[7:3] zero-extended (1-byte) or bits[12:3] (2-byte); bits[15:13] ignored.
REQ-017 SHALL latch llid/flow/pylen and pulse hdr_valid_p in the cycle following the last header bit strobe.
REQ-018 SHALL go HDR->DATA when pylen>0, HDR->CRC when pylen==0.
REQ-019 SHALL in DATA assemble 8 strobed bits LSB first into a byte and push it to the FIFO the cycle after the 8th bit; DATA->CRC after pylen bytes pushed.
REQ-020 SHALL in CRC ignore all strobed bits.
REQ-021 SHALL on dec_py_endp in HDR, DATA or CRC enter DONE; if not in CRC, set rx_trunc and discard any partial byte.
REQ-022 SHALL in DONE (one cycle) latch rx_crcok <= dec_crcgood, pulse rx_done_p, return to IDLE.
REQ-023 SHALL ignore dec_py_endp and bit strobes in IDLE and DONE.
REQ-024 SHALL provide an 8-entry byte FIFO, 3-bit pointers wrapping 7->0, 4-bit count 0..8, first-word fall-through.
REQ-025 SHALL on push when full and no pop drop the byte and set rx_ovf (sticky until next dec_py_st_p).
REQ-026 SHALL on simultaneous push and pop when full accept both, count unchanged.
REQ-027 SHALL ignore rd_p when empty; rxbyte is don't-care when rxbyte_avail=0.
REQ-028 SHALL use 10-bit byte counter comparing against pylen; max pylen 1023 without wrap.

Reset
REQ-029 SHALL on rstz low asynchronously force state IDLE, FIFO empty, counters 0.
REQ-030 SHALL reset all outputs to 0: rxbyte, rxbyte_avail, llid, flow, pylen, hdr_valid_p, rx_done_p, rx_crcok, rx_trunc, rx_ovf.
REQ-031 SHALL need no initialization beyond reset; first dec_py_st_p after reset is honoured.

Structure
REQ-032 SHALL place state encoding, FIFO depth (8) and header widths (8/16) in shared package py_pkg.
REQ-033 SHALL implement the FIFO as one sub-module py_bytefifo; FSM and header decode stay in py_rxasm.

Verification
REQ-034 1-byte header 0x1A (llid=2, flow=0, pylen=3), data 0x55,0xAA,0x0F, 16 CRC bits, dec_crcgood=1 -> hdr_valid_p once, pylen=3, three bytes popped in order, rx_done_p, rx_crcok=1, rx_trunc=0.
REQ-035 2-byte header pylen=10, no rd_p -> 8 bytes stored, rx_ovf=1, after endp popping yields first 8 bytes only.
REQ-036 Header pylen=0 -> HDR->CRC directly, no FIFO push, rx_done_p at endp.
REQ-037 dec_py_endp after 2.5 of 4 data bytes -> rx_trunc=1, exactly 2 bytes in FIFO, dec_crcgood=0 gives rx_crcok=0.
REQ-038 dec_py_st_p mid-DATA with 3 bytes buffered -> FIFO empty next cycle, new header decoded correctly.
REQ-039 rstz asserted mid-DATA -> all outputs 0 immediately; push with simultaneous pop at full -> count stays 8.
